vu_pwm_monitor: RTL

Receive-side companion to the VU meter PWM driver. It samples a VU PWM line (loopback of l_VU_out/r_VU_out, or an external meter-drive tap) and decodes the line back into a 7-bit duty value and a period measurement, each reported with a valid strobe. Each time base is 1 tick = CLK_DIV clk cycles, matching the driver's 768 kHz duty step at 49.152 MHz. It detects stuck-high and stuck-low lines for the self-test and status register path. One instance is used per channel.

---
 rtl/vu_pwm_monitor.sv | 95 +++++++++
 1 files changed

// File: rtl/vu_pwm_monitor.sv
// Receive-side decoder for a VU meter PWM line: measures duty and period in
// CLK_DIV-cycle ticks and flags lines stuck high or low.
module vu_pwm_monitor #(
  parameter int CLK_DIV       = 64,
  parameter int FRAME_TICKS   = 128,
  parameter int TIMEOUT_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pwm_in,
  output logic [6:0] duty_out,
  output logic [8:0] period_out,
  output logic       duty_valid,
  output logic       stuck_high,
  output logic       stuck_low
);

  localparam int               DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]    DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [8:0]       TMO      = 9'(TIMEOUT_TICKS);
  localparam logic [8:0]       HIGH_LIM = 9'(FRAME_TICKS - 1);
  localparam logic [6:0]       DUTY_MAX = 7'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  state_t        state;
  logic          pwm_m, pwm_s, pwm_s_d;
  logic [DW-1:0] div;
  logic [8:0]    high_cnt, period_cnt;
  logic          tick, rise, timeout;

  assign tick    = (state != IDLE) && (div == DIV_MAX);
  assign rise    = pwm_s & ~pwm_s_d;
  assign timeout = (period_cnt >= TMO);

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (&v) ? v : v + 9'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state      <= IDLE;
      pwm_m      <= 1'b0;
      pwm_s      <= 1'b0;
      pwm_s_d    <= 1'b0;
      div        <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      duty_out   <= '0;
      period_out <= '0;
      duty_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      pwm_m      <= pwm_in;
      pwm_s      <= pwm_m;
      pwm_s_d    <= pwm_s;
      duty_valid <= 1'b0;
      if (state != IDLE) div <= tick ? '0 : div + DW'(1);

      if (state == IDLE) begin
        state <= WAIT_RISE;
      end else if (rise) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
        state      <= MEASURE;
        if (state == MEASURE) begin
          duty_out   <= (high_cnt > HIGH_LIM) ? DUTY_MAX : high_cnt[6:0];
          period_out <= period_cnt;
          duty_valid <= 1'b1;
          // A tick coincident with the closing edge belongs to the new frame.
          high_cnt   <= {8'd0, tick};
          period_cnt <= {8'd0, tick};
        end else begin
          high_cnt   <= '0;
          period_cnt <= '0;
        end
      end else if (timeout) begin
        stuck_high <= pwm_s;
        stuck_low  <= ~pwm_s;
        duty_out   <= pwm_s ? DUTY_MAX : 7'd0;
        period_out <= '0;
        duty_valid <= 1'b1;
        high_cnt   <= '0;
        period_cnt <= '0;
        state      <= WAIT_RISE;
      end else if (tick) begin
        period_cnt <= sat_inc(period_cnt);
        if (pwm_s && state == MEASURE) high_cnt <= sat_inc(high_cnt);
      end
    end
  end

endmodule
